apb_master_arbiter: RTL and testbench

Shares one APB master port among NO_OF_REQUESTERS internal requesters using round-robin arbitration. Sequences the APB IDLE/SETUP/ACCESS/WAIT_STATE protocol and decodes paddr into a one-hot pselx over the slave address map. Enforces a wait-state timeout. Sits between test-side requesters (or DUT-side bus masters) and the APB slave interface.

---
 rtl/apb_master_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// apb_master_arbiter: round-robin sharing of one APB master port, with address decode and wait-state timeout.
// Revision 1.0
module apb_master_arbiter #(
  parameter int NO_OF_REQUESTERS  = 4,
  parameter int NO_OF_SLAVES      = 1,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_MEMORY_SIZE = 12,
  parameter int SLAVE_MEMORY_GAP  = 5,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                                      pclk,
  input  logic                                      preset,
  input  logic [NO_OF_REQUESTERS-1:0]               req,
  input  logic [NO_OF_REQUESTERS-1:0]               req_write,
  input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NO_OF_REQUESTERS*(DATA_WIDTH/8)-1:0] req_strb,
  input  logic [NO_OF_REQUESTERS*3-1:0]             req_prot,
  output logic [NO_OF_REQUESTERS-1:0]               done,
  output logic [DATA_WIDTH-1:0]                     rsp_rdata,
  output logic                                      rsp_slverr,
  output logic [NO_OF_SLAVES-1:0]                   pselx,
  output logic                                      penable,
  output logic                                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]                  paddr,
  output logic [DATA_WIDTH-1:0]                     pwdata,
  output logic [DATA_WIDTH/8-1:0]                   pstrb,
  output logic [2:0]                                pprot,
  input  logic                                      pready,
  input  logic [DATA_WIDTH-1:0]                     prdata,
  input  logic                                      pslverr,
  output logic [2:0]                                fsm_state
);

  localparam int GW = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [63:0] REGION_BYTES = 64'(SLAVE_MEMORY_SIZE) * 64'd1024;
  localparam logic [63:0] REGION_PITCH = REGION_BYTES + 64'(SLAVE_MEMORY_GAP);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd1,
    ST_SETUP      = 3'd2,
    ST_ACCESS     = 3'd3,
    ST_WAIT       = 3'd4,
    ST_DECODE_ERR = 3'd5
  } apb_fsm_state_e;

  apb_fsm_state_e            state_q, state_d;
  logic [GW-1:0]             last_grant;
  logic [GW-1:0]             pick;
  logic                      found;
  logic [CW-1:0]             wait_cnt;
  logic [NO_OF_SLAVES-1:0]   dec_sel;
  logic [ADDRESS_WIDTH-1:0]  sel_addr;
  logic [63:0]               base;
  logic [63:0]               addr64;
  logic [GW-1:0]             idx;
  logic                      timeout;
  logic                      complete;
  logic                      complete_err;

  logic [ADDRESS_WIDTH-1:0]  addr_arr  [NO_OF_REQUESTERS];
  logic [DATA_WIDTH-1:0]     wdata_arr [NO_OF_REQUESTERS];
  logic [SW-1:0]             strb_arr  [NO_OF_REQUESTERS];
  logic [2:0]                prot_arr  [NO_OF_REQUESTERS];

  for (genvar g = 0; g < NO_OF_REQUESTERS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[g]  = req_strb[g*SW +: SW];
    assign prot_arr[g]  = req_prot[g*3 +: 3];
  end

  // Search starts one past the last winner so every requester is reached within N grants.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
      idx = GW'((int'(last_grant) + 1 + i) % NO_OF_REQUESTERS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign sel_addr = addr_arr[pick];

  always_comb begin
    dec_sel = '0;
    base    = '0;
    addr64  = 64'(sel_addr);
    for (int k = 0; k < NO_OF_SLAVES; k++) begin
      base = 64'(k) * REGION_PITCH;
      if (addr64 >= base && addr64 < base + REGION_BYTES) dec_sel[k] = 1'b1;
    end
  end

  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    complete     = 1'b0;
    complete_err = 1'b0;
    done         = '0;
    rsp_rdata    = '0;
    rsp_slverr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) state_d = (|dec_sel) ? ST_SETUP : ST_DECODE_ERR;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS, ST_WAIT: begin
        if (pready) begin
          state_d  = ST_IDLE;
          complete = 1'b1;
        end else if (timeout) begin
          state_d      = ST_IDLE;
          complete_err = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DECODE_ERR: begin
        state_d      = ST_IDLE;
        complete_err = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A transfer aborted by reset must not report completion.
    if (!preset) begin
      if (complete) begin
        done[last_grant] = 1'b1;
        rsp_rdata        = pwrite ? '0 : prdata;
        rsp_slverr       = pslverr;
      end else if (complete_err) begin
        done[last_grant] = 1'b1;
        rsp_slverr       = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      last_grant <= GW'(NO_OF_REQUESTERS - 1);
      wait_cnt   <= '0;
      pselx      <= '0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      pprot      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            last_grant <= pick;
            pwrite     <= req_write[pick];
            paddr      <= sel_addr;
            pwdata     <= wdata_arr[pick];
            pstrb      <= strb_arr[pick];
            pprot      <= prot_arr[pick];
            pselx      <= dec_sel;
          end
        end
        ST_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ST_ACCESS, ST_WAIT: begin
          if (state_d == ST_IDLE) begin
            pselx   <= '0;
            penable <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// tb_apb_master_arbiter: vector table plus timeout and reset-abort sequences.
// Revision 1.0
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            pclk = 1'b0;
  logic            preset;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N*3-1:0]  req_prot;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic [1:0]      pselx;
  logic            penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [2:0]      pprot;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;
  logic [2:0]      fsm_state;

  apb_master_arbiter #(
    .NO_OF_REQUESTERS(N), .NO_OF_SLAVES(2), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_MEMORY_SIZE(12), .SLAVE_MEMORY_GAP(5), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .fsm_state(fsm_state)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [3:0]  mask;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] prd;
    logic        serr;
    int          waits;
    int          grant;
    logic [1:0]  sel;
    logic        decerr;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
  } vec_t;

  vec_t vecs [10];
  vec_t last_vec;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_all(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr);
    for (int i = 0; i < N; i++) begin
      req_write[i]        = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = wd;
      req_strb[i*SW +: SW] = st;
      req_prot[i*3 +: 3]   = pr;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("v%0d", n);
    @(negedge pclk);
    req = v.mask;
    load_all(v.wr, v.addr, v.wdata, v.strb, v.prot);
    pready = 1'b0; prdata = v.prd; pslverr = v.serr;
    #1;
    chk({tag, " idle_state"}, fsm_state, 3'd1);
    chk({tag, " idle_pselx"}, pselx, 2'b00);
    chk({tag, " idle_done"}, done, 4'b0000);
    @(negedge pclk);
    // Fields change after the grant; the bus must keep the latched values.
    load_all(!v.wr, 32'h0000_1234, ~v.wdata, ~v.strb, ~v.prot);
    #1;
    if (v.decerr) begin
      chk({tag, " derr_state"}, fsm_state, 3'd5);
      chk({tag, " derr_done"}, done, 64'd1 << v.grant);
      chk({tag, " derr_slverr"}, rsp_slverr, 1'b1);
      chk({tag, " derr_rdata"}, rsp_rdata, 32'h0);
      chk({tag, " derr_pselx"}, pselx, 2'b00);
      chk({tag, " derr_penable"}, penable, 1'b0);
    end else begin
      chk({tag, " setup_state"}, fsm_state, 3'd2);
      chk({tag, " setup_pselx"}, pselx, v.sel);
      chk({tag, " setup_penable"}, penable, 1'b0);
      chk({tag, " setup_done"}, done, 4'b0000);
      chk({tag, " setup_paddr"}, paddr, v.addr);
      chk({tag, " setup_pwrite"}, pwrite, v.wr);
      chk({tag, " setup_pwdata"}, pwdata, v.wdata);
      chk({tag, " setup_pstrb"}, pstrb, v.strb);
      chk({tag, " setup_pprot"}, pprot, v.prot);
      for (int w = 0; w <= v.waits; w++) begin
        @(negedge pclk);
        pready = (w == v.waits);
        #1;
        chk({tag, " acc_state"}, fsm_state, (w == 0) ? 3'd3 : 3'd4);
        chk({tag, " acc_penable"}, penable, 1'b1);
        chk({tag, " acc_pselx"}, pselx, v.sel);
        chk({tag, " acc_paddr"}, paddr, v.addr);
        chk({tag, " acc_pwrite"}, pwrite, v.wr);
        if (w == v.waits) begin
          chk({tag, " done"}, done, 64'd1 << v.grant);
          chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
          chk({tag, " slverr"}, rsp_slverr, v.exp_slverr);
        end else begin
          chk({tag, " wait_done"}, done, 4'b0000);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{4'b0001, 1'b1, 32'h10,   32'hA5A5_A5A5, 4'hF, 3'd0, 32'h0,         1'b0, 0, 0, 2'b01, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{4'b0001, 1'b0, 32'h20,   32'h0,         4'h0, 3'd2, 32'h1234_5678, 1'b0, 3, 0, 2'b01, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{4'b1111, 1'b1, 32'h100,  32'h1122_3344, 4'h3, 3'd1, 32'h0,         1'b0, 0, 1, 2'b01, 1'b0, 32'h0,         1'b0};
    vecs[3] = '{4'b1111, 1'b0, 32'h2FFF, 32'h0,         4'h0, 3'd5, 32'hCAFE_F00D, 1'b1, 0, 2, 2'b01, 1'b0, 32'hCAFE_F00D, 1'b1};
    vecs[4] = '{4'b1111, 1'b1, 32'h3005, 32'hDEAD_BEEF, 4'hC, 3'd7, 32'h0,         1'b0, 1, 3, 2'b10, 1'b0, 32'h0,         1'b0};
    vecs[5] = '{4'b1111, 1'b0, 32'h3004, 32'h0,         4'h0, 3'd0, 32'h0,         1'b0, 0, 0, 2'b00, 1'b1, 32'h0,         1'b1};
    vecs[6] = '{4'b1111, 1'b0, 32'h3000, 32'h0,         4'h0, 3'd3, 32'h99,        1'b0, 0, 1, 2'b00, 1'b1, 32'h0,         1'b1};
    vecs[7] = '{4'b1100, 1'b0, 32'h6004, 32'h0,         4'h0, 3'd4, 32'h0BAD_BEEF, 1'b0, 2, 2, 2'b10, 1'b0, 32'h0BAD_BEEF, 1'b0};
    vecs[8] = '{4'b0001, 1'b1, 32'h6005, 32'h5,         4'h1, 3'd0, 32'h0,         1'b0, 0, 0, 2'b00, 1'b1, 32'h0,         1'b1};
    vecs[9] = '{4'b1010, 1'b1, 32'h40,   32'h77,        4'hF, 3'd6, 32'hFFFF_FFFF, 1'b1, 2, 1, 2'b01, 1'b0, 32'h0,         1'b1};
    last_vec = '{4'b1111, 1'b1, 32'h8, 32'hABCD, 4'hF, 3'd0, 32'h0, 1'b0, 0, 0, 2'b01, 1'b0, 32'h0, 1'b0};

    preset = 1'b1; req = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    load_all(1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    repeat (2) @(negedge pclk);
    #1;
    chk("rst_state", fsm_state, 3'd1);
    chk("rst_pselx", pselx, 2'b00);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_pprot", pprot, 3'h0);
    chk("rst_done", done, 4'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_slverr", rsp_slverr, 1'b0);
    @(negedge pclk);
    preset = 1'b0;

    for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

    // Timeout: requester 0 wins (last grant 1, requesters 2 and 3 idle), pready never rises.
    @(negedge pclk);
    req = 4'b0001; load_all(1'b0, 32'h50, 32'h0, 4'h0, 3'd0);
    pready = 1'b0; prdata = 32'h55; pslverr = 1'b0;
    #1 chk("to_idle", fsm_state, 3'd1);
    @(negedge pclk); #1 chk("to_setup", fsm_state, 3'd2);
    for (int c = 1; c <= 16; c++) begin
      @(negedge pclk); #1;
      chk("to_state", fsm_state, (c == 1) ? 3'd3 : 3'd4);
      chk("to_done", done, (c == 16) ? 4'b0001 : 4'b0000);
      if (c == 16) begin
        chk("to_slverr", rsp_slverr, 1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
      end
    end
    @(negedge pclk);
    req = '0;
    #1;
    chk("to_after_state", fsm_state, 3'd1);
    chk("to_after_pselx", pselx, 2'b00);
    chk("to_after_penable", penable, 1'b0);

    // Reset during WAIT_STATE: requester 2 granted, then aborted.
    @(negedge pclk);
    req = 4'b0100; load_all(1'b0, 32'h60, 32'h0, 4'h0, 3'd1);
    #1 chk("rs_idle", fsm_state, 3'd1);
    @(negedge pclk); #1 chk("rs_setup", fsm_state, 3'd2);
    @(negedge pclk); #1 chk("rs_access", fsm_state, 3'd3);
    @(negedge pclk); #1 chk("rs_wait", fsm_state, 3'd4);
    @(negedge pclk);
    preset = 1'b1; pready = 1'b1; prdata = 32'h7777;
    #1;
    chk("rs_wait2", fsm_state, 3'd4);
    chk("rs_no_done", done, 4'b0000);
    @(negedge pclk);
    preset = 1'b0; req = '0; pready = 1'b0;
    #1;
    chk("rs_after_state", fsm_state, 3'd1);
    chk("rs_after_pselx", pselx, 2'b00);
    chk("rs_after_penable", penable, 1'b0);
    chk("rs_after_paddr", paddr, 32'h0);
    chk("rs_after_done", done, 4'b0000);
    run_vec(last_vec, 10);

    @(negedge pclk);
    req = '0; pready = 1'b0;
    #1 chk("end_state", fsm_state, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
